// File: rtl/tick_ctrl.sv
// Run/pause/clear controller that produces a prescaled count-enable tick for a downstream timer.
// Latency: a switch change reaches the FSM after 2 sync cycles plus DEB_CYCLES debounce cycles.
// No backpressure: tick and clr_pulse are fire-and-forget single-cycle pulses.
module tick_ctrl #(
   parameter int CLK_SET    = 5_000_000,
   parameter int DEB_CYCLES = 50_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sw_run,
   input  logic       sw_clr,
   output logic       tick,
   output logic       clr_pulse,
   output logic       running,
   output logic [1:0] state
);

   localparam int CW = $clog2(CLK_SET);
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_SET - 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10
   } state_t;

   logic          run_meta_q, run_meta_d, s_run_q, s_run_d;
   logic          clr_meta_q, clr_meta_d, s_clr_q, s_clr_d;
   logic          run_db_q, run_db_d, clr_db_q, clr_db_d;
   logic [DW-1:0] run_dc_q, run_dc_d, clr_dc_q, clr_dc_d;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;
   logic          clr_pulse_q, clr_pulse_d;
   logic          running_q, running_d;

   // Two-flop synchronizers: the raw switches are only ever seen through s_run_q / s_clr_q.
   always_comb begin
      run_meta_d = sw_run;
      s_run_d    = run_meta_q;
      clr_meta_d = sw_clr;
      s_clr_d    = clr_meta_q;
   end

   // Debouncers: accept a new level only after it has differed from db for DEB_CYCLES samples.
   always_comb begin
      run_db_d = run_db_q;
      run_dc_d = '0;
      if (s_run_q != run_db_q) begin
         if (run_dc_q == DEB_LAST) begin
            run_db_d = s_run_q;
         end else begin
            run_dc_d = run_dc_q + 1'b1;
         end
      end
      clr_db_d = clr_db_q;
      clr_dc_d = '0;
      if (s_clr_q != clr_db_q) begin
         if (clr_dc_q == DEB_LAST) begin
            clr_db_d = s_clr_q;
         end else begin
            clr_dc_d = clr_dc_q + 1'b1;
         end
      end
   end

   // FSM next state: clear wins over everything, otherwise the run switch steers IDLE/RUN/PAUSE.
   always_comb begin
      state_d = state_q;
      if (clr_db_q) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (run_db_q)  state_d = RUN;
            RUN:     if (!run_db_q) state_d = PAUSE;
            PAUSE:   if (run_db_q)  state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
      running_d   = (state_d == RUN);
      clr_pulse_d = clr_db_d & ~clr_db_q;
   end

   // Prescaler: advances only across edges where the FSM stays in RUN, so a tick can never land
   // in the cycle after leaving RUN and a pause resumes from exactly the held count.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (state_d == IDLE) begin
         cnt_d = '0;
      end else if (state_q == RUN && state_d == RUN) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // All state registers; reset clears everything so a switch high at release counts as fresh.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_meta_q  <= 1'b0;
         s_run_q     <= 1'b0;
         clr_meta_q  <= 1'b0;
         s_clr_q     <= 1'b0;
         run_db_q    <= 1'b0;
         run_dc_q    <= '0;
         clr_db_q    <= 1'b0;
         clr_dc_q    <= '0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         tick_q      <= 1'b0;
         clr_pulse_q <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         run_meta_q  <= run_meta_d;
         s_run_q     <= s_run_d;
         clr_meta_q  <= clr_meta_d;
         s_clr_q     <= s_clr_d;
         run_db_q    <= run_db_d;
         run_dc_q    <= run_dc_d;
         clr_db_q    <= clr_db_d;
         clr_dc_q    <= clr_dc_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tick_q      <= tick_d;
         clr_pulse_q <= clr_pulse_d;
         running_q   <= running_d;
      end
   end

   assign tick      = tick_q;
   assign clr_pulse = clr_pulse_q;
   assign running   = running_q;
   assign state     = state_q;

endmodule

// File: doc/tick_ctrl.md
TICK_CTRL -- requirements
Module: tick_ctrl

Interface
REQ-001 Parameter CLK_SET, default 5_000_000, tick period in clk cycles; legal range >= 2.
REQ-002 Parameter DEB_CYCLES, default 50_000, consecutive stable cycles required to accept a switch change; legal range >= 1.
REQ-003 Port clk  input  1  single clock; every flop in the block is clocked on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port sw_run  input  1  raw slide switch, asynchronous to clk; 1 = run, 0 = pause.
REQ-006 Port sw_clr  input  1  raw slide switch, asynchronous to clk; 1 = clear and hold.
REQ-007 Port tick  output  1  one-cycle count-enable pulse for the downstream timer.
REQ-008 Port clr_pulse  output  1  one-cycle clear pulse for the downstream timer.
REQ-009 Port running  output  1  high while the FSM is in RUN.
REQ-010 Port state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10; 11 is unused.

Function
REQ-011 Each switch shall pass through a two-flop synchronizer (s_run, s_clr) before any other use.
REQ-012 Each synchronized switch shall have its own debouncer: a registered value db and a counter dc of width $clog2(DEB_CYCLES+1).
REQ-013 Debouncer, when s == db: dc <= 0.
REQ-014 Debouncer, when s != db and dc < DEB_CYCLES-1: dc <= dc+1.
REQ-015 Debouncer, when s != db and dc == DEB_CYCLES-1: db <= s and dc <= 0.
REQ-016 A glitch shorter than DEB_CYCLES synchronized cycles shall not change db.
REQ-017 FSM transitions use the registered debounced values run_db and clr_db; each transition takes effect on the edge after the debounced value changes.
REQ-018 Transition priority: clr_db=1 forces IDLE from any state and overrides run_db.
REQ-019 IDLE -> RUN when clr_db=0 and run_db=1.
REQ-020 RUN -> PAUSE when run_db=0.
REQ-021 PAUSE -> RUN when run_db=1.
REQ-022 Prescaler cnt, width $clog2(CLK_SET), in IDLE: cnt <= 0.
REQ-023 Prescaler in PAUSE: cnt holds its value.
REQ-024 Prescaler in RUN, when cnt == CLK_SET-1: cnt <= 0 and tick <= 1.
REQ-025 Prescaler in RUN, otherwise: cnt <= cnt+1 and tick <= 0.
REQ-026 tick is registered; it is 0 in every cycle the FSM is not in RUN, including the cycle after leaving RUN.
REQ-027 The first tick after entering RUN from IDLE shall occur CLK_SET cycles after the entry edge; later ticks shall follow every CLK_SET cycles.
REQ-028 RUN -> PAUSE -> RUN shall resume from the held cnt, so no partial period is lost or restarted.
REQ-029 clr_pulse is registered and high for exactly one cycle after the edge at which clr_db rises; holding clr_db high shall not repeat the pulse.
REQ-030 running == (state == RUN); running and state are registered.

Reset
REQ-031 While rst=1, all outputs shall be 0: tick, clr_pulse, running, and state=IDLE.
REQ-032 While rst=1, all internal state shall be 0: synchronizer flops, db, dc and cnt.
REQ-033 A switch already high at reset release is a fresh change: it is accepted only after synchronization plus DEB_CYCLES.
REQ-034 rst asserted mid-RUN shall immediately drop tick and running, and shall discard the partial count.

Verification
Common bench setup: CLK_SET=4, DEB_CYCLES=3; edge 0 is the first clk edge after sw_run rises.
REQ-035 Start and period: sw_run 0->1 before edge 0 -> run_db=1 after edge 4; state=RUN and running=1 after edge 5; tick high after edges 9, 13, 17.
REQ-036 Debounce reject: sw_run high for 2 cycles, then low -> run_db stays 0; state stays IDLE; no tick.
REQ-037 Pause and resume: with cnt=2 in RUN, sw_run goes low -> PAUSE and cnt holds 2. Restore sw_run -> RUN; the first tick comes 2 cycles after RUN re-entry.
REQ-038 Clear priority: in RUN with sw_run=1, sw_clr goes high -> exactly one clr_pulse; state=IDLE and cnt=0 for as long as clr is held. Release sw_clr -> RUN is re-entered after the debounce, and the first tick comes 4 cycles after re-entry.
REQ-039 Async reset: assert rst mid-period, between clk edges -> tick, running and state are 0 before the next clk edge. Release rst with sw_run=1 -> RUN is re-entered only after the full sync plus DEB_CYCLES delay.
